ysyx_24090013_keytable: RTL and testbench



---
 rtl/ysyx_24090013_keytable_pkg.sv | 19 +
 rtl/ysyx_24090013_keytable_match.sv | 33 +++
 rtl/ysyx_24090013_keytable.sv | 183 ++++++++++++++++++
 tb/tb_ysyx_24090013_keytable.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24090013_keytable_pkg.sv
// Shared definitions for the key/value table: default sizes, FSM encoding, pair width helper.
// Optional same-cycle write-to-lookup bypass is enabled by defining YSYX_24090013_KEYTABLE_BYPASS_EN.
package ysyx_24090013_keytable_pkg;

  localparam int NR_KEY_DEF   = 4;
  localparam int KEY_LEN_DEF  = 8;
  localparam int DATA_LEN_DEF = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } kt_state_e;

  // One LUT pair is {key, data}, key in the upper bits.
  function automatic int pair_len(input int key_len, input int data_len);
    return key_len + data_len;
  endfunction

endpackage

// File: rtl/ysyx_24090013_keytable_match.sv
// Combinational key compare against every valid table entry: one-hot hit, any-hit and OR-selected data.
// Keys are unique in the table, so at most one bit of hit_oh_o is ever set.
module ysyx_24090013_keytable_match
  import ysyx_24090013_keytable_pkg::*;
#(
  parameter int NR_KEY   = NR_KEY_DEF,
  parameter int KEY_LEN  = KEY_LEN_DEF,
  parameter int DATA_LEN = DATA_LEN_DEF
) (
  input  logic [KEY_LEN-1:0]                              key_i,
  input  logic [NR_KEY*pair_len(KEY_LEN, DATA_LEN)-1:0]   lut_i,
  input  logic [NR_KEY-1:0]                               vld_i,
  output logic [NR_KEY-1:0]                               hit_oh_o,
  output logic                                            any_hit_o,
  output logic [DATA_LEN-1:0]                             data_o
);

  localparam int PAIR_LEN = pair_len(KEY_LEN, DATA_LEN);

  always_comb begin
    hit_oh_o = '0;
    data_o   = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (vld_i[i] && (lut_i[i*PAIR_LEN+DATA_LEN +: KEY_LEN] == key_i)) begin
        hit_oh_o[i] = 1'b1;
        data_o      = data_o | lut_i[i*PAIR_LEN +: DATA_LEN];
      end
    end
  end

  assign any_hit_o = |hit_oh_o;

endmodule

// File: rtl/ysyx_24090013_keytable.sv
// Run-time programmable key/value table driving a packed LUT, with registered lookups and a flush sweep.
// Define YSYX_24090013_KEYTABLE_BYPASS_EN to let a same-cycle lookup see the data being written.
module ysyx_24090013_keytable
  import ysyx_24090013_keytable_pkg::*;
#(
  parameter int NR_KEY   = NR_KEY_DEF,
  parameter int KEY_LEN  = KEY_LEN_DEF,
  parameter int DATA_LEN = DATA_LEN_DEF
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            wr_valid,
  output logic                                            wr_ready,
  input  logic [KEY_LEN-1:0]                              wr_key,
  input  logic [DATA_LEN-1:0]                             wr_data,
  input  logic                                            flush,
  output logic                                            flush_busy,
  input  logic                                            lk_valid,
  output logic                                            lk_ready,
  input  logic [KEY_LEN-1:0]                              lk_key,
  input  logic [DATA_LEN-1:0]                             default_data,
  output logic                                            rsp_valid,
  input  logic                                            rsp_ready,
  output logic [DATA_LEN-1:0]                             rsp_data,
  output logic                                            rsp_hit,
  output logic [NR_KEY*pair_len(KEY_LEN, DATA_LEN)-1:0]   lut,
  output logic [NR_KEY-1:0]                               lut_vld
);

  localparam int PAIR_LEN = pair_len(KEY_LEN, DATA_LEN);
  localparam int IDX_W    = $clog2(NR_KEY);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_KEY - 1);

  kt_state_e                    state_q;
  logic [IDX_W-1:0]             flush_idx_q;
  logic [IDX_W-1:0]             victim_q, victim_d;
  logic [NR_KEY*PAIR_LEN-1:0]   lut_q, lut_d;
  logic [NR_KEY-1:0]            vld_q, vld_d;
  logic                         rsp_valid_q;
  logic                         rsp_hit_q, rsp_hit_d;
  logic [DATA_LEN-1:0]          rsp_data_q, rsp_data_d;

  logic                         wr_fire, lk_fire;
  logic [NR_KEY-1:0]            wr_hit_oh, lk_hit_oh, slot_oh;
  logic                         wr_any_hit, lk_any_hit, free_found, use_victim;
  logic [DATA_LEN-1:0]          lk_match_data, wr_match_data_unused;
  logic                         bypass_hit;

  assign wr_ready = (state_q == IDLE) && !flush;
  assign lk_ready = (state_q == IDLE) && !flush && (!rsp_valid_q || rsp_ready);
  assign wr_fire  = wr_valid && wr_ready;
  assign lk_fire  = lk_valid && lk_ready;

  ysyx_24090013_keytable_match #(
    .NR_KEY  (NR_KEY),
    .KEY_LEN (KEY_LEN),
    .DATA_LEN(DATA_LEN)
  ) u_wr_match (
    .key_i    (wr_key),
    .lut_i    (lut_q),
    .vld_i    (vld_q),
    .hit_oh_o (wr_hit_oh),
    .any_hit_o(wr_any_hit),
    .data_o   (wr_match_data_unused)
  );

  ysyx_24090013_keytable_match #(
    .NR_KEY  (NR_KEY),
    .KEY_LEN (KEY_LEN),
    .DATA_LEN(DATA_LEN)
  ) u_lk_match (
    .key_i    (lk_key),
    .lut_i    (lut_q),
    .vld_i    (vld_q),
    .hit_oh_o (lk_hit_oh),
    .any_hit_o(lk_any_hit),
    .data_o   (lk_match_data)
  );

  // Slot priority: existing key, then lowest free entry, then round-robin victim.
  always_comb begin
    slot_oh    = '0;
    free_found = 1'b0;
    use_victim = 1'b0;
    if (wr_any_hit) begin
      slot_oh = wr_hit_oh;
    end else begin
      for (int i = 0; i < NR_KEY; i++) begin
        if (!vld_q[i] && !free_found) begin
          slot_oh[i] = 1'b1;
          free_found = 1'b1;
        end
      end
      if (!free_found) begin
        slot_oh[victim_q] = 1'b1;
        use_victim        = 1'b1;
      end
    end
  end

  always_comb begin
    lut_d    = lut_q;
    vld_d    = vld_q;
    victim_d = victim_q;
    if (wr_fire) begin
      for (int i = 0; i < NR_KEY; i++) begin
        if (slot_oh[i]) begin
          lut_d[i*PAIR_LEN +: PAIR_LEN] = {wr_key, wr_data};
          vld_d[i]                      = 1'b1;
        end
      end
      if (use_victim) begin
        victim_d = (victim_q == LAST_IDX) ? '0 : victim_q + 1'b1;
      end
    end
    if (state_q == FLUSH) begin
      vld_d[flush_idx_q] = 1'b0;
    end
  end

`ifdef YSYX_24090013_KEYTABLE_BYPASS_EN
  assign bypass_hit = wr_fire && (wr_key == lk_key);
`else
  assign bypass_hit = 1'b0;
`endif

  always_comb begin
    rsp_hit_d  = lk_any_hit;
    rsp_data_d = lk_any_hit ? lk_match_data : default_data;
    if (bypass_hit) begin
      rsp_hit_d  = 1'b1;
      rsp_data_d = wr_data;
    end
  end

  // Flush sweep clears one valid bit per cycle; the response slot is independent of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      flush_idx_q <= '0;
      victim_q    <= '0;
      lut_q       <= '0;
      vld_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      lut_q    <= lut_d;
      vld_q    <= vld_d;
      victim_q <= victim_d;
      case (state_q)
        IDLE: begin
          if (flush) begin
            state_q     <= FLUSH;
            flush_idx_q <= '0;
          end
        end
        FLUSH: begin
          if (flush_idx_q == LAST_IDX) begin
            state_q <= IDLE;
          end else begin
            flush_idx_q <= flush_idx_q + 1'b1;
          end
        end
      endcase
      if (lk_fire) begin
        rsp_valid_q <= 1'b1;
        rsp_hit_q   <= rsp_hit_d;
        rsp_data_q  <= rsp_data_d;
      end else if (rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign flush_busy = (state_q == FLUSH);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_hit    = rsp_hit_q;
  assign rsp_data   = rsp_data_q;
  assign lut        = lut_q;
  assign lut_vld    = vld_q;

endmodule

// File: tb/tb_ysyx_24090013_keytable.sv
// Self-checking bench for ysyx_24090013_keytable: reference table model plus a response scoreboard queue.
// Honours YSYX_24090013_KEYTABLE_BYPASS_EN the same way as the design.
module tb_ysyx_24090013_keytable;

  localparam int NK = 4;
  localparam int KL = 8;
  localparam int DL = 32;
  localparam int PL = KL + DL;

  logic              clk;
  logic              rst_n;
  logic              wr_valid;
  logic              wr_ready;
  logic [KL-1:0]     wr_key;
  logic [DL-1:0]     wr_data;
  logic              flush;
  logic              flush_busy;
  logic              lk_valid;
  logic              lk_ready;
  logic [KL-1:0]     lk_key;
  logic [DL-1:0]     default_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DL-1:0]     rsp_data;
  logic              rsp_hit;
  logic [NK*PL-1:0]  lut;
  logic [NK-1:0]     lut_vld;

  int total = 0;
  int bad   = 0;

  logic [KL-1:0]     mKey [NK];
  logic [DL-1:0]     mData[NK];
  logic [NK-1:0]     mVld;
  int                mVictim;
  logic              mBusy;
  int                mFlushIdx;
  logic [DL:0]       rspQ[$];

  ysyx_24090013_keytable #(
    .NR_KEY  (NK),
    .KEY_LEN (KL),
    .DATA_LEN(DL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_key      (wr_key),
    .wr_data     (wr_data),
    .flush       (flush),
    .flush_busy  (flush_busy),
    .lk_valid    (lk_valid),
    .lk_ready    (lk_ready),
    .lk_key      (lk_key),
    .default_data(default_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_hit     (rsp_hit),
    .lut         (lut),
    .lut_vld     (lut_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [NK*PL-1:0] packModel();
    logic [NK*PL-1:0] v;
    v = '0;
    for (int i = 0; i < NK; i++) v[i*PL +: PL] = {mKey[i], mData[i]};
    return v;
  endfunction

  task automatic clearModel();
    for (int i = 0; i < NK; i++) begin
      mKey[i]  = '0;
      mData[i] = '0;
    end
    mVld      = '0;
    mVictim   = 0;
    mBusy     = 1'b0;
    mFlushIdx = 0;
    rspQ.delete();
  endtask

  // Checks the current cycle against the model, then advances model and DUT by one clock.
  task automatic cycleStep();
    logic        expWrRdy, expLkRdy, wrFire, lkFire, hit;
    logic [DL-1:0] dat;
    int          slot;
    #1;
    expWrRdy = !mBusy && !flush;
    expLkRdy = expWrRdy && ((rspQ.size() == 0) || rsp_ready);
    checkOutput("wr_ready", wr_ready, expWrRdy);
    checkOutput("lk_ready", lk_ready, expLkRdy);
    checkOutput("flush_busy", flush_busy, mBusy);
    checkOutput("rsp_valid", rsp_valid, rspQ.size() != 0);
    if (rspQ.size() != 0) begin
      checkOutput("rsp_hit", rsp_hit, rspQ[0][DL]);
      checkOutput("rsp_data", rsp_data, rspQ[0][DL-1:0]);
    end
    checkOutput("lut_vld", lut_vld, mVld);
    checkOutput("lut", lut, packModel());

    wrFire = wr_valid && expWrRdy;
    lkFire = lk_valid && expLkRdy;
    if (rspQ.size() != 0 && rsp_ready) void'(rspQ.pop_front());
    if (lkFire) begin
      hit = 1'b0;
      dat = default_data;
      for (int i = 0; i < NK; i++) begin
        if (mVld[i] && mKey[i] == lk_key) begin
          hit = 1'b1;
          dat = mData[i];
        end
      end
`ifdef YSYX_24090013_KEYTABLE_BYPASS_EN
      if (wrFire && wr_key == lk_key) begin
        hit = 1'b1;
        dat = wr_data;
      end
`endif
      rspQ.push_back({hit, dat});
    end
    if (wrFire) begin
      slot = -1;
      for (int i = 0; i < NK; i++) if (mVld[i] && mKey[i] == wr_key) slot = i;
      if (slot < 0) for (int i = 0; i < NK; i++) if (!mVld[i] && slot < 0) slot = i;
      if (slot < 0) begin
        slot    = mVictim;
        mVictim = (mVictim + 1) % NK;
      end
      mKey[slot]  = wr_key;
      mData[slot] = wr_data;
      mVld[slot]  = 1'b1;
    end
    if (mBusy) begin
      mVld[mFlushIdx] = 1'b0;
      if (mFlushIdx == NK - 1) mBusy = 1'b0;
      else mFlushIdx++;
    end else if (flush) begin
      mBusy     = 1'b1;
      mFlushIdx = 0;
    end
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic wv, input logic [KL-1:0] wk, input logic [DL-1:0] wd,
                               input logic lv, input logic [KL-1:0] lk, input logic fl, input logic rr);
    wr_valid  = wv;
    wr_key    = wk;
    wr_data   = wd;
    lk_valid  = lv;
    lk_key    = lk;
    flush     = fl;
    rsp_ready = rr;
    cycleStep();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n        = 1'b0;
    wr_valid     = 1'b0;
    wr_key       = '0;
    wr_data      = '0;
    flush        = 1'b0;
    lk_valid     = 1'b0;
    lk_key       = '0;
    rsp_ready    = 1'b0;
    default_data = 32'hDEAD;
    clearModel();
    #12;
    checkOutput("reset_rsp_valid", rsp_valid, 1'b0);
    checkOutput("reset_rsp_data", rsp_data, 32'h0);
    checkOutput("reset_rsp_hit", rsp_hit, 1'b0);
    checkOutput("reset_flush_busy", flush_busy, 1'b0);
    checkOutput("reset_lut", lut, '0);
    checkOutput("reset_lut_vld", lut_vld, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] lookup on empty table");
    applyStimulus(1'b0, '0, '0, 1'b1, 8'h05, 1'b0, 1'b1);
    checkOutput("empty_miss_hit", rsp_hit, 1'b0);
    checkOutput("empty_miss_data", rsp_data, 32'hDEAD);
    idle(1);

    $display("[TB] insert and update");
    applyStimulus(1'b1, 8'h05, 32'h11, 1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1, 8'h05, 1'b0, 1'b1);
    checkOutput("hit_05", {rsp_hit, rsp_data}, {1'b1, 32'h11});
    applyStimulus(1'b1, 8'h05, 32'h22, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("update_same_slot", lut_vld, 4'b0001);
    applyStimulus(1'b0, '0, '0, 1'b1, 8'h05, 1'b0, 1'b1);
    checkOutput("hit_05_updated", {rsp_hit, rsp_data}, {1'b1, 32'h22});
    idle(1);

    $display("[TB] flush sweep with blocked requests");
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < NK; i++) applyStimulus(1'b1, 8'h30, 32'h30, 1'b1, 8'h05, (i == 1), 1'b1);
    idle(1);
    checkOutput("post_flush_vld", lut_vld, 4'b0000);

    $display("[TB] fill and victim replacement");
    for (int k = 1; k <= 4; k++) applyStimulus(1'b1, 8'(k), 32'h100 + 32'(k), 1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h09, 32'h99, 1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h0A, 32'hAA, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("victim_slot0_key", lut[PL-1 -: KL], 8'h09);
    applyStimulus(1'b0, '0, '0, 1'b1, 8'h01, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1, 8'h09, 1'b0, 1'b1);
    idle(1);

    $display("[TB] response backpressure");
    applyStimulus(1'b0, '0, '0, 1'b1, 8'h0A, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, '0, 1'b1, 8'h02, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 8'h02, 1'b0, 1'b1);
    idle(1);

    $display("[TB] same-cycle write and lookup");
    applyStimulus(1'b1, 8'h07, 32'h77, 1'b1, 8'h07, 1'b0, 1'b1);
`ifdef YSYX_24090013_KEYTABLE_BYPASS_EN
    checkOutput("same_cycle_07", {rsp_hit, rsp_data}, {1'b1, 32'h77});
`else
    checkOutput("same_cycle_07", {rsp_hit, rsp_data}, {1'b0, 32'hDEAD});
`endif
    idle(1);

    $display("[TB] flush with pending response");
    applyStimulus(1'b0, '0, '0, 1'b1, 8'h07, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    idle(NK + 1);
    applyStimulus(1'b0, '0, '0, 1'b1, 8'h03, 1'b0, 1'b1);
    idle(1);

    $display("[TB] random traffic");
    default_data = 32'hBEEF;
    for (int i = 0; i < 80; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(1, 6)), $urandom,
                    1'($urandom_range(0, 1)), 8'($urandom_range(1, 6)),
                    ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
    end
    idle(NK + 2);

    $display("[TB] async reset with pending response");
    applyStimulus(1'b1, 8'h0B, 32'hB0, 1'b1, 8'h03, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rsp_valid", rsp_valid, 1'b0);
    checkOutput("async_lut_vld", lut_vld, 4'b0000);
    checkOutput("async_lut", lut, '0);
    clearModel();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
